// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types for the sequential ALU: operation and state
//                encodings plus the packed flag bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative unsigned WIDTH x WIDTH shift-add multiplier.
//                One partial product per clock; 'product' presents the value
//                after the current step so the parent can capture it on the
//                same edge at which 'last' is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_next;

  // Add the multiplicand into the high half when the current multiplier bit is set,
  // then shift the whole accumulator (including the add carry) right by one.
  assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_next  = {w_add, r_acc[WIDTH-1:1]};

  assign busy    = r_busy;
  assign last    = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign product = w_next;

  // Load operands on request, then run exactly WIDTH shift-add steps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (load) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= a;
      r_acc   <= {{WIDTH{1'b0}}, b};
    end else if (r_busy) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule : alu_mul_seq
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Registered eight-operation ALU with start/done handshake.
//                Single-cycle ops finish one edge after acceptance; MUL runs
//                on the iterative multiplier and finishes WIDTH edges later.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  state_e             r_state;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  flags_t             r_flags;

  logic               w_accept;
  logic               w_mul_load;
  logic               w_mul_busy;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_prod;
  flags_t             w_mul_flg;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SHW-1:0]     w_k;
  logic               w_shbig;
  logic [WIDTH-1:0]   w_res;
  flags_t             w_flg;

  // New requests are only taken when no operation is in flight
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_mul_load = w_accept && (op_e'(sel) == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (w_mul_load),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .last    (w_mul_last),
    .product (w_prod)
  );

  // Extended-width arithmetic: the extra MSB is carry-out / borrow / shifted-out bit
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_k     = r_b[SHW-1:0];
  assign w_shbig = |r_b[WIDTH-1:SHW];
  assign w_shl   = {1'b0, r_a} << w_k;
  assign w_shr   = {r_a, 1'b0} >> w_k;

  assign w_mul_flg.carry = |w_prod[2*WIDTH-1:WIDTH];
  assign w_mul_flg.zero  = (w_prod == '0);
  assign w_mul_flg.neg   = w_prod[WIDTH-1];
  assign w_mul_flg.ovf   = |w_prod[2*WIDTH-1:WIDTH];

  // Single-cycle result and flags from the registered operands
  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (r_op)
      OP_ADD: begin
        w_res     = w_sum[WIDTH-1:0];
        w_flg.carry = w_sum[WIDTH];
        w_flg.ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res     = w_diff[WIDTH-1:0];
        w_flg.carry = ~w_diff[WIDTH];
        w_flg.ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        if (!w_shbig) begin
          {w_flg.carry, w_res} = w_shl;
        end
      end
      OP_SHR: begin
        if (!w_shbig) begin
          {w_res, w_flg.carry} = w_shr;
        end
      end
      default: w_res = '0;
    endcase
    w_flg.zero = (w_res == '0);
    w_flg.neg  = w_res[WIDTH-1];
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op_e'(sel);
            r_cin   <= cin;
            r_busy  <= 1'b1;
            r_state <= (op_e'(sel) == OP_MUL) ? MUL : EXEC;
          end else begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          r_result    <= w_res;
          r_result_hi <= '0;
          r_flags     <= w_flg;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        MUL: begin
          if (w_mul_last) begin
            r_result    <= w_prod[WIDTH-1:0];
            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_flags     <= w_mul_flg;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else if (!w_mul_busy) begin
            // Multiplier idle without finishing: recover rather than hang
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign carry     = r_flags.carry;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;
  assign ovf       = r_flags.ovf;

endmodule : alu_seq_unit
`default_nettype wire

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised, registered successor of the board-level combinational ALU/prefix-adder pair. It takes WIDTH-bit operands through a start/done handshake and executes eight operations. Single-cycle ops complete in a fixed latency; multiply uses an iterative shift-add datapath. It sits between the switch/button input capture logic and the LED/7-segment display controller, and presents registered result and flag outputs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.
SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  3  operation select
cin  input  1  carry-in for ADD only
busy  output  1  high in EXEC and MUL states
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  low result word
result_hi  output  WIDTH  high product word for MUL; 0 for all other ops
carry  output  1  carry / no-borrow / shifted-out bit / product overflow
zero  output  1  result (full 2*WIDTH product for MUL) equals 0
neg  output  1  result[WIDTH-1]
ovf  output  1  signed overflow (ADD/SUB) or result_hi!=0 (MUL); 0 otherwise

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Sampled high at any edge, in any state: state becomes IDLE, multiply counter clears, and every output is driven 0 (busy, done, result, result_hi, carry, zero, neg, ovf). An in-flight operation is discarded with no done pulse.
- States: IDLE, EXEC, MUL, DONE.
- IDLE/DONE with start=1 at edge N:
  - Register a, b, sel and cin.
  - Next state is MUL when sel=111, else EXEC.
  - start=0 in DONE returns the state to IDLE.
- start is ignored in EXEC and MUL; no queueing.
- EXEC: at edge N+1, compute from the registered operands, load result and flags, go to DONE. done is high for exactly the cycle after edge N+1.
- MUL: shift-add multiply, one partial product per edge.
  - At edge N+WIDTH, load the 2*WIDTH-bit product ({result_hi, result}), go to DONE. done is high for the cycle after edge N+WIDTH.
  - busy stays high for WIDTH cycles.
- result, result_hi and the flags hold their values until the next completion or reset. done is a pulse; the other outputs are level-held.
- Operations (sel):
  - 000 ADD: a+b+cin; carry = bit WIDTH of the sum.
  - 001 SUB: a-b; carry = 1 when a>=b unsigned (no borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0, ovf=0.
  - 101 SHL by k=b[SHW-1:0]: carry = a[WIDTH-k] for k>=1, carry=0 for k=0.
  - 110 SHR (logical) by k: carry = a[k-1] for k>=1, carry=0 for k=0.
  - 111 MUL: unsigned; carry = ovf = |result_hi.
  - If b has any bit set at or above SHW, a shift returns result=0 and carry=0.
- Signed overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
- Reset has priority over start at the same edge.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum (OP_ADD..OP_MUL, 3 bits).
  - state_e enum (IDLE, EXEC, MUL, DONE).
  - Flag struct {carry, zero, neg, ovf}.
- Sub-module alu_mul_seq:
  - Iterative WIDTH x WIDTH shift-add multiplier with its own counter.
  - Ports: load, busy, last, product[2*WIDTH].
  - The parent FSM drives load and consumes last.

Test Plan:
- Reset: rst=1 for 2 edges during a MUL -> all outputs 0, busy=0, no done; a following ADD 1+1 then gives result=0x02.
- ADD, WIDTH=8, a=0xF0, b=0x1F, cin=1 -> result=0x10, carry=1, zero=0, ovf=0; done pulses exactly once, in the cycle after edge N+1.
- SUB, a=0x05, b=0x07 -> result=0xFE, carry=0, neg=1, ovf=0. SUB, a=0x80, b=0x01 -> result=0x7F, ovf=1, carry=1.
- MUL, a=0xFF, b=0xFF -> result=0x01, result_hi=0xFE, carry=1, ovf=1. busy high 8 cycles; done after edge N+8; a start pulse mid-operation is ignored.
- SHL, a=0x81, b=0x01 -> result=0x02, carry=1. SHL, b=0x08 -> result=0, carry=0. SHR, a=0x81, b=0x01 -> result=0x40, carry=1.
- Back-to-back: start held high through DONE -> second op accepted on the done cycle. WIDTH=16 regression: MUL 0xFFFF*0x0002 -> result=0xFFFE, result_hi=0x0001, done after 16 edges.
